// File: rtl/store_merge_unit.sv
// Store merge unit: turns SB/SH/SW into read-modify-write sequences on a
// word-wide data memory port that has no byte enables.
module store_merge_unit #(
  parameter bit WORD_FAST = 1'b1
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        StoreValidM,
  input  logic [1:0]  StoreSizeM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] MemRD,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  output logic        StallM,
  output logic        MisalignedM
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } stateT;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  stateT       state;
  stateT       nextState;
  logic [31:0] capAddr;
  logic [31:0] capData;
  logic [1:0]  capSize;
  logic [31:0] readWord;
  logic [31:0] mergedWord;
  logic [31:0] wordAddr;
  logic        misaligned;
  logic        accept;
  logic        reject;

  always_comb begin
    misaligned = 1'b0;
    unique case (StoreSizeM)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = AddrM[0];
      SIZE_WORD: misaligned = |AddrM[1:0];
      default:   misaligned = 1'b1;
    endcase
  end

  assign accept   = (state == IDLE) && StoreValidM && !misaligned;
  assign reject   = (state == IDLE) && StoreValidM && misaligned;
  assign wordAddr = {capAddr[31:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Upstream may change its inputs once the store is accepted, so everything
  // needed later comes from these registers.
  always_ff @(posedge CLK) begin
    if (!Rst) begin
      capAddr     <= '0;
      capData     <= '0;
      capSize     <= '0;
      readWord    <= '0;
      MisalignedM <= 1'b0;
    end else begin
      if (accept) begin
        capAddr <= AddrM;
        capData <= WriteDataM;
        capSize <= StoreSizeM;
      end
      if ((state == READ) && MemAck) begin
        readWord <= MemRD;
      end
      MisalignedM <= reject;
    end
  end

  always_comb begin
    mergedWord = readWord;
    unique case (capSize)
      SIZE_BYTE: begin
        unique case (capAddr[1:0])
          2'd0:    mergedWord[7:0]   = capData[7:0];
          2'd1:    mergedWord[15:8]  = capData[7:0];
          2'd2:    mergedWord[23:16] = capData[7:0];
          default: mergedWord[31:24] = capData[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (capAddr[1]) begin
          mergedWord[31:16] = capData[15:0];
        end else begin
          mergedWord[15:0] = capData[15:0];
        end
      end
      default: mergedWord = capData;
    endcase
  end

  // Stall is gated by reset so a flushed pipeline never sees a stale stall.
  always_comb begin
    nextState = state;
    MemReq    = 1'b0;
    MemWE     = 1'b0;
    MemAddr   = '0;
    MemWD     = '0;
    StallM    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          StallM = Rst;
          if ((StoreSizeM == SIZE_WORD) && WORD_FAST) begin
            nextState = WRITE;
          end else begin
            nextState = READ;
          end
        end
      end
      READ: begin
        MemReq  = 1'b1;
        MemAddr = wordAddr;
        StallM  = 1'b1;
        if (MemAck) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        MemReq  = 1'b1;
        MemWE   = 1'b1;
        MemAddr = wordAddr;
        MemWD   = mergedWord;
        StallM  = 1'b1;
        if (MemAck) begin
          nextState = DONE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule
